// File: rtl/seq_mult_acc.sv
// Shift-and-add multiplier with optional accumulate: one 2*WIDTH-bit adder is
// reused over WIDTH cycles; product/cout load on the final add and done then pulses for one cycle.
module seq_mult_acc #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               cout
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   m_reg;
  logic [PW-1:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]   cnt;
  logic            c_reg;
  logic [PW:0]     sum;
  logic [PW-1:0]   p_nxt;
  logic            c_nxt;

  always_comb begin
    sum   = {1'b0, p_reg} + {1'b0, m_reg};
    p_nxt = q_reg[0] ? sum[PW-1:0] : p_reg;
    c_nxt = c_reg | (q_reg[0] & sum[PW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      p_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      c_reg   <= 1'b0;
      product <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m_reg <= {{WIDTH{1'b0}}, a};
          q_reg <= b;
          cnt   <= '0;
          p_reg <= acc ? product : '0;
          c_reg <= 1'b0;
        end
        RUN: begin
          p_reg <= p_nxt;
          c_reg <= c_nxt;
          m_reg <= m_reg << 1;
          q_reg <= q_reg >> 1;
          cnt   <= cnt + 1'b1;
          // Result registers load on the last add so they are valid while done is high.
          if (cnt == LAST) begin
            product <= p_nxt;
            cout    <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_acc.sv
// Directed bench for seq_mult_acc at WIDTH=4 and WIDTH=8.
module tb_seq_mult_acc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start8 = 1'b0, acc = 1'b0;
  logic [3:0]  a = '0, b = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy, done, cout, busy8, done8, cout8;
  logic [7:0]  product;
  logic [15:0] product8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_acc #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc(acc), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .cout(cout)
  );

  seq_mult_acc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .acc(acc), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8), .cout(cout8)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on either instance; checks busy/done every cycle, product
  // stability before done, and result on and after the done cycle.
  task automatic op(input bit wide, input logic [7:0] ta, input logic [7:0] tbv,
                    input logic tacc, input logic [15:0] ep, input logic ec, input string tag);
    int lat;
    logic [15:0] prev;
    lat  = wide ? 9 : 5;
    prev = wide ? product8 : {8'h00, product};
    @(negedge clk);
    if (wide) begin a8 = ta; b8 = tbv; start8 = 1'b1; end
    else begin a = ta[3:0]; b = tbv[3:0]; start = 1'b1; end
    acc = tacc;
    @(posedge clk);
    #1;
    start = 1'b0; start8 = 1'b0;
    a = ~a; b = ~b; a8 = ~a8; b8 = ~b8; acc = ~acc;
    for (int i = 1; i <= lat + 2; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, wide ? busy8 : busy, (i <= lat) ? 16'd1 : 16'd0);
      chk({tag, " done"}, wide ? done8 : done, (i == lat) ? 16'd1 : 16'd0);
      if (i < lat)
        chk({tag, " product stable"}, wide ? product8 : {8'h00, product}, prev);
      else begin
        chk({tag, " product"}, wide ? product8 : {8'h00, product}, ep);
        chk({tag, " cout"}, wide ? cout8 : cout, {15'd0, ec});
      end
    end
  endtask

  initial begin
    #12;
    chk("reset busy", busy, 16'd0);
    chk("reset done", done, 16'd0);
    chk("reset product", product, 16'd0);
    chk("reset cout", cout, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 8'd15, 8'd15, 1'b0, 16'h00E1, 1'b0, "T1 15x15");
    op(1'b0, 8'd15, 8'd15, 1'b1, 16'h00C2, 1'b1, "T2 acc 15x15");
    op(1'b0, 8'd3,  8'd2,  1'b1, 16'h00C8, 1'b0, "T2 acc 3x2");
    op(1'b0, 8'd0,  8'd9,  1'b0, 16'h0000, 1'b0, "T3 0x9");
    op(1'b0, 8'd9,  8'd9,  1'b0, 16'h0051, 1'b0, "9x9");
    op(1'b0, 8'd10, 8'd0,  1'b1, 16'h0051, 1'b0, "acc b=0");

    // T4: start held high; operands change during RUN
    @(negedge clk);
    a = 4'd5; b = 4'd7; acc = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 4'd2; b = 4'd2;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("T4 busy", busy, 16'd1);
      chk("T4 done", done, (i == 5) ? 16'd1 : 16'd0);
    end
    chk("T4 product", product, 16'h0023);
    @(negedge clk);
    chk("T4 idle gap", busy, 16'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("T4 second busy", busy, 16'd1);
      chk("T4 second done", done, (i == 5) ? 16'd1 : 16'd0);
    end
    chk("T4 second product", product, 16'h0004);

    // T5: reset in the middle of RUN
    @(negedge clk);
    a = 4'd13; b = 4'd11; acc = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("T5 running", busy, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("T5 reset busy", busy, 16'd0);
    chk("T5 reset done", done, 16'd0);
    chk("T5 reset product", product, 16'd0);
    chk("T5 reset cout", cout, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("T5 no done", done, 16'd0);
      chk("T5 stays idle", busy, 16'd0);
    end
    op(1'b0, 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, "T5 13x11");

    op(1'b1, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0, "W8 255x255");
    op(1'b1, 8'd255, 8'd255, 1'b1, 16'hFC02, 1'b1, "W8 acc 255x255");
    op(1'b1, 8'd16,  8'd16,  1'b1, 16'hFD02, 1'b0, "W8 acc 16x16");
    op(1'b1, 8'd200, 8'd3,   1'b0, 16'h0258, 1'b0, "W8 200x3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
